// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address overlay, frame layout and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_IDX_W  = 4;
  localparam int ICACHE_TAG_W  = 30 - ICACHE_IDX_W;
  // Sized for the smallest legal cache (2 frames); unused upper tag bits stay zero.
  localparam int ICACHE_TAG_MAX_W = 29;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
    word_t                       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, one-word fill on a miss
// over the iREN/iwait handshake, fill abandoned if the datapath drops imemREN.
module icache
  import cpu_types_pkg::*;
#(
  parameter int NFRAMES = 16
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  localparam int IDXW = $clog2(NFRAMES);
  localparam int TAGW = 30 - IDXW;

  icache_state_t state;
  word_t         miss_addr;
  icache_frame_t frames [NFRAMES];

  logic [IDXW-1:0] req_idx, miss_idx;
  logic [TAGW-1:0] req_tag, miss_tag;
  icache_frame_t   req_frame;
  logic            lookup_hit;

  assign req_idx  = imemaddr[1+IDXW:2];
  assign req_tag  = imemaddr[31:2+IDXW];
  assign miss_idx = miss_addr[1+IDXW:2];
  assign miss_tag = miss_addr[31:2+IDXW];

  assign req_frame  = frames[req_idx];
  assign lookup_hit = req_frame.valid &&
                      (req_frame.tag == ICACHE_TAG_MAX_W'(req_tag));

  // Hits are only served from IDLE; a lookup during FETCH must not bypass the pending fill.
  assign ihit     = imemREN && lookup_hit && (state == IDLE);
  assign imemload = ihit ? req_frame.data : '0;
  assign iREN     = (state == FETCH);
  assign iaddr    = {miss_addr[31:2], 2'b00};

  // Byte offsets never select anything in a word-granular cache.
  logic unused_offset;
  assign unused_offset = ^{imemaddr[1:0], miss_addr[1:0]};

  // NOTE: the frame array is kept in flops rather than a RAM macro precisely so the
  // asynchronous reset can invalidate every frame at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      miss_addr <= '0;
      for (int i = 0; i < NFRAMES; i++) begin
        frames[i] <= '0;
      end
    end else begin
      // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
      case (state)
        IDLE: begin
          if (imemREN && !lookup_hit) begin
            miss_addr <= imemaddr;
            state     <= FETCH;
          end
        end
        FETCH: begin
          // Abort takes priority over data arrival: a yielded fetch never writes.
          if (!imemREN) begin
            state <= IDLE;
          end else if (!iwait) begin
            frames[miss_idx] <= '{valid: 1'b1,
                                  tag:   ICACHE_TAG_MAX_W'(miss_tag),
                                  data:  iload};
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: reset, cold miss, hits, conflict, abort,
// address change during fetch and reset during fetch.
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  int n_cmp = 0;
  int n_err = 0;

  icache #(.NFRAMES(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Advance to 2 time units after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Stimulus only: start a miss on a from IDLE, hold iwait high for waits FETCH cycles,
  // then deliver d. Reports how many cycles iREN was seen high and whether iaddr held.
  task automatic do_fill(input word_t a, input int waits, input word_t d,
                         output int ren_cyc, output logic addr_ok);
    ren_cyc  = 0;
    addr_ok  = 1'b1;
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = '0;
    tick();
    for (int i = 0; i <= waits; i++) begin
      iwait = (i < waits);
      iload = (i < waits) ? 32'h0 : d;
      #1;
      if (iREN) ren_cyc++;
      if (iaddr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
      tick();
    end
    iwait = 1'b1;
    iload = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; iload = 32'hFFFF_FFFF;
    #12;
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL reset_ihit: got %b want 0", ihit); end
    n_cmp++; if (imemload !== 32'h0) begin n_err++; $display("FAIL reset_imemload: got %h want 0", imemload); end
    n_cmp++; if (iREN !== 1'b0) begin n_err++; $display("FAIL reset_iREN: got %b want 0", iREN); end
    n_cmp++; if (iaddr !== 32'h0) begin n_err++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
    imemREN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    int   ren;
    logic ok;
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL cold_c0_ihit: got %b want 0", ihit); end
    n_cmp++; if (iREN !== 1'b0) begin n_err++; $display("FAIL cold_c0_iREN: got %b want 0", iREN); end
    do_fill(32'h40, 3, 32'h8C01_0004, ren, ok);
    n_cmp++; if (ren !== 4) begin n_err++; $display("FAIL cold_iREN_cycles: got %0d want 4", ren); end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL cold_iaddr: iaddr left 0x40 during FETCH (last %h)", iaddr); end
    #1;
    n_cmp++; if (ihit !== 1'b1) begin n_err++; $display("FAIL cold_after_ihit: got %b want 1", ihit); end
    n_cmp++; if (imemload !== 32'h8C01_0004) begin n_err++; $display("FAIL cold_after_load: got %h want 8c010004", imemload); end
    n_cmp++; if (iREN !== 1'b0) begin n_err++; $display("FAIL cold_after_iREN: got %b want 0", iREN); end
  endtask

  task automatic test_hit();
    word_t addrs [3] = '{32'h40, 32'h42, 32'h43};
    foreach (addrs[k]) begin
      imemREN = 1'b1; imemaddr = addrs[k];
      #1;
      n_cmp++; if (ihit !== 1'b1) begin n_err++; $display("FAIL hit_ihit[%h]: got %b want 1", addrs[k], ihit); end
      n_cmp++; if (imemload !== 32'h8C01_0004) begin n_err++; $display("FAIL hit_load[%h]: got %h want 8c010004", addrs[k], imemload); end
      n_cmp++; if (iREN !== 1'b0) begin n_err++; $display("FAIL hit_iREN[%h]: got %b want 0", addrs[k], iREN); end
      tick();
    end
    imemREN = 1'b0;
    imemaddr = 32'h40;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL hit_no_ren: got %b want 0", ihit); end
    n_cmp++; if (imemload !== 32'h0) begin n_err++; $display("FAIL hit_no_ren_load: got %h want 0", imemload); end
    tick();
  endtask

  task automatic test_conflict();
    int   ren;
    logic ok;
    do_fill(32'h80, 1, 32'h1111_1111, ren, ok);
    n_cmp++; if (ren !== 2) begin n_err++; $display("FAIL conflict_iREN_cycles: got %0d want 2", ren); end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL conflict_iaddr: iaddr left 0x80 (last %h)", iaddr); end
    #1;
    n_cmp++; if (imemload !== 32'h1111_1111) begin n_err++; $display("FAIL conflict_load80: got %h want 11111111", imemload); end
    imemaddr = 32'h40;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL conflict_evict40: got ihit %b want 0", ihit); end
    do_fill(32'h40, 0, 32'h8C01_0004, ren, ok);
    n_cmp++; if (ren !== 1) begin n_err++; $display("FAIL conflict_min_penalty: got %0d want 1", ren); end
    #1;
    n_cmp++; if (imemload !== 32'h8C01_0004) begin n_err++; $display("FAIL conflict_refill40: got %h want 8c010004", imemload); end
    imemREN = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
    tick();
    #1;
    n_cmp++; if (iREN !== 1'b1) begin n_err++; $display("FAIL abort_c1_iREN: got %b want 1", iREN); end
    n_cmp++; if (iaddr !== 32'h100) begin n_err++; $display("FAIL abort_c1_iaddr: got %h want 100", iaddr); end
    tick();
    imemREN = 1'b0; iwait = 1'b0; iload = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (iREN !== 1'b1) begin n_err++; $display("FAIL abort_c2_iREN: got %b want 1", iREN); end
    tick();
    iwait = 1'b1; iload = '0;
    #1;
    n_cmp++; if (iREN !== 1'b0) begin n_err++; $display("FAIL abort_idle_iREN: got %b want 0", iREN); end
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    n_cmp++; if (imemload !== 32'h8C01_0004) begin n_err++; $display("FAIL abort_frame_kept: got %h want 8c010004", imemload); end
    imemaddr = 32'h100;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL abort_remiss: got ihit %b want 0", ihit); end
    imemREN = 1'b0;
    tick();
  endtask

  task automatic test_addr_change();
    imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1;
    tick();
    imemaddr = 32'h204;
    #1;
    n_cmp++; if (iaddr !== 32'h200) begin n_err++; $display("FAIL chg_c1_iaddr: got %h want 200", iaddr); end
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL chg_c1_ihit: got %b want 0", ihit); end
    tick();
    iwait = 1'b0; iload = 32'hA5A5_0200;
    #1;
    n_cmp++; if (iaddr !== 32'h200) begin n_err++; $display("FAIL chg_c2_iaddr: got %h want 200", iaddr); end
    tick();
    iwait = 1'b1; iload = '0;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL chg_204_miss: got ihit %b want 0", ihit); end
    tick();
    #1;
    n_cmp++; if (iREN !== 1'b1) begin n_err++; $display("FAIL chg_204_fetch_iREN: got %b want 1", iREN); end
    n_cmp++; if (iaddr !== 32'h204) begin n_err++; $display("FAIL chg_204_fetch_iaddr: got %h want 204", iaddr); end
    imemREN = 1'b0;
    tick();
    imemREN = 1'b1; imemaddr = 32'h200;
    #1;
    n_cmp++; if (ihit !== 1'b1) begin n_err++; $display("FAIL chg_200_hit: got %b want 1", ihit); end
    n_cmp++; if (imemload !== 32'hA5A5_0200) begin n_err++; $display("FAIL chg_200_load: got %h want a5a50200", imemload); end
    imemREN = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL rstf_pre_miss40: got ihit %b want 0", ihit); end
    tick();
    #1;
    n_cmp++; if (iREN !== 1'b1) begin n_err++; $display("FAIL rstf_fetch_iREN: got %b want 1", iREN); end
    RST = 1'b1; iwait = 1'b0; iload = 32'h1234_5678;
    #1;
    n_cmp++; if (iREN !== 1'b0) begin n_err++; $display("FAIL rstf_async_iREN: got %b want 0", iREN); end
    tick();
    RST = 1'b0; iwait = 1'b1; iload = '0;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL rstf_40_miss: got ihit %b want 0", ihit); end
    imemaddr = 32'h200;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL rstf_200_miss: got ihit %b want 0", ihit); end
    imemREN = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_abort();
    test_addr_change();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
